// File: rtl/pc_next_gen.sv
// pc_next_gen: next-PC select and fetch control with buffered mid-fetch redirects
module pc_next_gen #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc,
    input  logic [31:0]      imm_ext,
    input  logic [31:0]      alu_result,
    input  logic [1:0]       pc_src,
    input  logic             stall,
    input  logic             imem_ready,
    output logic             fetch_req,
    output logic [31:0]      pc_next,
    output logic [31:0]      pc_plus4,
    output logic             misaligned,
    output logic [CNT_W-1:0] redirect_cnt
);
    typedef enum logic [1:0] {S_BOOT, S_WAIT, S_STALL} state_t;
    state_t      state;
    logic        pend_valid;
    logic [31:0] pend_target;
    logic        redir;
    logic        apply;
    logic [31:0] tgt;
    logic [31:0] applied;
    assign pc_plus4  = pc + 32'd4;
    assign redir     = pc_src == 2'b01 || pc_src == 2'b10;
    assign tgt       = pc_src == 2'b01 ? pc + imm_ext : pc_src == 2'b10 ? {alu_result[31:1], 1'b0} : pc_plus4;
    // leaving S_STALL delivers the already-fetched instruction's target, so it applies like an advance
    assign apply     = !stall && ((state == S_WAIT && imem_ready) || state == S_STALL);
    assign applied   = pend_valid ? pend_target : tgt;
    assign fetch_req = state == S_WAIT;
    assign pc_next   = state == S_BOOT ? RESET_PC : apply ? {applied[31:2], 2'b00} : pc;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_BOOT;
            pend_valid   <= 1'b0;
            pend_target  <= 32'd0;
            misaligned   <= 1'b0;
            redirect_cnt <= '0;
        end else begin
            if (state == S_BOOT)
                state <= S_WAIT;
            else if (state == S_WAIT && imem_ready && stall)
                state <= S_STALL;
            else if (state == S_STALL && !stall)
                state <= S_WAIT;
            if (state == S_WAIT && !imem_ready && redir) begin
                pend_valid  <= 1'b1;
                pend_target <= tgt;
            end
            if (apply) begin
                pend_valid <= 1'b0;
                if (applied[1])
                    misaligned <= 1'b1;
                if ((pend_valid || redir) && !(&redirect_cnt))
                    redirect_cnt <= redirect_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pc_next_gen.sv
// tb_pc_next_gen: directed vectors against a rule-level model of next-PC selection
module tb_pc_next_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [31:0] imm_ext = 32'd0;
    logic [31:0] alu_result = 32'd0;
    logic [1:0]  pc_src = 2'd0;
    logic        stall = 1'b0;
    logic        imem_ready = 1'b0;
    logic        fetch_req;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic [15:0] redirect_cnt;

    pc_next_gen dut (
        .clk(clk), .rst(rst), .pc(pc), .imm_ext(imm_ext), .alu_result(alu_result),
        .pc_src(pc_src), .stall(stall), .imem_ready(imem_ready), .fetch_req(fetch_req),
        .pc_next(pc_next), .pc_plus4(pc_plus4), .misaligned(misaligned), .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: boot flag, stalled flag, pending-target queue (depth <= 1, newest wins)
    bit          m_boot = 1'b1;
    bit          m_stall = 1'b0;
    bit          m_mis = 1'b0;
    int unsigned m_cnt = 0;
    logic [31:0] m_pend[$];
    logic [31:0] m_a;

    function automatic bit redir_in();
        return pc_src == 2'd1 || pc_src == 2'd2;
    endfunction
    function automatic logic [31:0] tgt_in();
        return pc_src == 2'd1 ? pc + imm_ext : pc_src == 2'd2 ? (alu_result & 32'hFFFF_FFFE) : pc + 32'd4;
    endfunction
    function automatic bit applies();
        return !m_boot && !stall && (m_stall || imem_ready);
    endfunction
    function automatic logic [31:0] src();
        return m_pend.size() != 0 ? m_pend[0] : tgt_in();
    endfunction
    function automatic logic [31:0] exp_pc_next();
        return m_boot ? 32'd0 : applies() ? (src() & 32'hFFFF_FFFC) : pc;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_boot = 1'b1;
            m_stall = 1'b0;
            m_mis = 1'b0;
            m_cnt = 0;
            m_pend.delete();
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (applies()) begin
            m_a = src();
            if (m_a[1]) m_mis = 1'b1;
            if ((m_pend.size() != 0 || redir_in()) && m_cnt < 65535) m_cnt++;
            m_pend.delete();
            m_stall = 1'b0;
        end else if (!m_stall && imem_ready) begin
            m_stall = 1'b1;
        end else if (!m_stall && !imem_ready && redir_in()) begin
            m_pend = {tgt_in()};
        end
    end

    always @(negedge clk) begin
        chk("m_fetch_req", {31'd0, fetch_req}, {31'd0, !m_boot && !m_stall});
        chk("m_pc_next", pc_next, exp_pc_next());
        chk("m_pc_plus4", pc_plus4, pc + 32'd4);
        chk("m_misaligned", {31'd0, misaligned}, {31'd0, m_mis});
        chk("m_redirect_cnt", {16'd0, redirect_cnt}, m_cnt);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        mid(); chk("boot_pc", pc_next, 32'd0); chk("boot_req", {31'd0, fetch_req}, 32'd0);
        cyc(); imem_ready = 1'b1; pc = 32'd0; pc_src = 2'd0;
        mid(); chk("seq_4", pc_next, 32'd4); chk("seq_req", {31'd0, fetch_req}, 32'd1);
        cyc(); pc = 32'd4;
        mid(); chk("seq_8", pc_next, 32'd8);
        cyc(); pc = 32'd8;
        mid(); chk("seq_12", pc_next, 32'd12); chk("seq_cnt", {16'd0, redirect_cnt}, 32'd0);
        cyc(); pc = 32'd40; imem_ready = 1'b0; pc_src = 2'd1; imm_ext = 32'hFFFF_FFF0;
        mid(); chk("wait_hold1", pc_next, 32'd40);
        cyc(); pc_src = 2'd0;
        mid(); chk("wait_hold2", pc_next, 32'd40);
        cyc();
        mid(); chk("wait_hold3", pc_next, 32'd40);
        cyc(); imem_ready = 1'b1;
        mid(); chk("pend_apply", pc_next, 32'd24);
        cyc(); pc = 32'd100; stall = 1'b1;
        mid(); chk("pend_cnt", {16'd0, redirect_cnt}, 32'd1); chk("stall_enter", pc_next, 32'd100);
        cyc();
        mid(); chk("stall_hold", pc_next, 32'd100); chk("stall_req", {31'd0, fetch_req}, 32'd0);
        cyc(); stall = 1'b0; pc_src = 2'd2; alu_result = 32'd205;
        mid(); chk("jalr_exit", pc_next, 32'd204);
        cyc(); pc = 32'd204; pc_src = 2'd0;
        mid(); chk("jalr_cnt", {16'd0, redirect_cnt}, 32'd2); chk("after_stall", pc_next, 32'd208);
        cyc(); pc = 32'hFFFF_FFFC;
        mid(); chk("wrap", pc_next, 32'd0);
        cyc(); pc = 32'd8; pc_src = 2'd1; imm_ext = 32'd6;
        mid(); chk("misal_pc", pc_next, 32'd12); chk("misal_pre", {31'd0, misaligned}, 32'd0);
        cyc(); pc = 32'd12; pc_src = 2'd0;
        mid(); chk("misal_set", {31'd0, misaligned}, 32'd1); chk("seq_16", pc_next, 32'd16);
        cyc();
        mid(); chk("misal_sticky", {31'd0, misaligned}, 32'd1); chk("cnt3", {16'd0, redirect_cnt}, 32'd3);
        cyc(); pc = 32'd40; imem_ready = 1'b0; pc_src = 2'd1; imm_ext = 32'd8;
        mid(); chk("pend2_hold", pc_next, 32'd40);
        cyc(); pc_src = 2'd0;
        #2 rst = 1'b0;
        #1;
        chk("arst_pc", pc_next, 32'd0); chk("arst_req", {31'd0, fetch_req}, 32'd0);
        chk("arst_cnt", {16'd0, redirect_cnt}, 32'd0); chk("arst_mis", {31'd0, misaligned}, 32'd0);
        cyc();
        #2 rst = 1'b1;
        mid(); chk("reboot_req", {31'd0, fetch_req}, 32'd0);
        cyc(); imem_ready = 1'b1;
        mid(); chk("no_stale_pend", pc_next, 32'd44); chk("reboot_fetch", {31'd0, fetch_req}, 32'd1);
        cyc();
        mid(); chk("reboot_cnt", {16'd0, redirect_cnt}, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
